// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Stall/flush sequencer and fetch-redirect handshake for the
//            five-stage core, with stall and redirect performance counters.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_busy,
  input  logic            mem_busy,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_redirect_pc,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            mem_wb_bubble,
  output logic            fetch_redirect,
  output logic [XLEN-1:0] fetch_redirect_pc,
  output logic            fetch_discard,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     redirect_cnt
);

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    DISCARD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [31:0]     redirect_cnt_q, redirect_cnt_d;
  logic            load_use;

  always_comb begin
    load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    pc_en             = 1'b1;
    if_id_en          = 1'b1;
    id_ex_en          = 1'b1;
    ex_mem_en         = 1'b1;
    mem_wb_en         = 1'b1;
    if_id_flush       = 1'b0;
    id_ex_flush       = 1'b0;
    mem_wb_bubble     = 1'b0;
    fetch_redirect    = 1'b0;
    fetch_redirect_pc = redirect_pc_q;
    fetch_discard     = 1'b0;
    state_d           = state_q;
    redirect_pc_d     = redirect_pc_q;
    redirect_cnt_d    = redirect_cnt_q;

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
      state_d       = NORMAL;
    end else if (state_q == DISCARD) begin
      // EX holds a bubble here, so only MEM back-pressure shapes the downstream.
      pc_en         = 1'b0;
      if_id_flush   = 1'b1;
      fetch_discard = if_busy;
      if (mem_busy) begin
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      if (!if_busy) begin
        fetch_redirect    = 1'b1;
        fetch_redirect_pc = redirect_pc_q;
        state_d           = NORMAL;
      end
    end else if (mem_busy) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_valid && ex_redirect) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_cnt_d = redirect_cnt_q + 32'd1;
      if (if_busy) begin
        redirect_pc_d = ex_redirect_pc;
        state_d       = DISCARD;
      end else begin
        fetch_redirect    = 1'b1;
        fetch_redirect_pc = ex_redirect_pc;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (if_busy) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end

    stall_cnt_d = stall_cnt_q + {31'd0, (!pc_en && !fetch_redirect)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= NORMAL;
      redirect_pc_q  <= '0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed plus randomized bench for pipeline_ctrl against a
//            rule-level reference model.
// Revision : 1.0
// ============================================================================
module tb_pipeline_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_busy, mem_busy;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2;
  logic            ex_valid, ex_is_load, ex_redirect;
  logic [XLEN-1:0] ex_redirect_pc;
  logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic            if_id_flush, id_ex_flush, mem_wb_bubble;
  logic            fetch_redirect, fetch_discard;
  logic [XLEN-1:0] fetch_redirect_pc;
  logic [31:0]     stall_cnt, redirect_cnt;

  pipeline_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .fetch_redirect(fetch_redirect), .fetch_redirect_pc(fetch_redirect_pc),
    .fetch_discard(fetch_discard), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a pending redirect waiting for fetch to go idle.
  bit              m_pending;
  logic [XLEN-1:0] m_target;
  logic [31:0]     m_stall, m_redir;
  bit              prev_redirect;

  // Expected outputs and which of them are pinned down for the current case
  bit              e_pc, e_ifid, e_idex, e_exmem, e_memwb;
  bit              e_ifid_fl, e_idex_fl, e_bub, e_redir, e_disc;
  logic [XLEN-1:0] e_rpc;
  bit              care_ifid, care_idex, e_take, e_enter;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit hz;
    hz = ex_valid && ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
    {e_ifid_fl, e_idex_fl, e_bub, e_redir, e_disc} = 5'b00000;
    e_rpc = '0; care_ifid = 1; care_idex = 1; e_take = 0; e_enter = 0;
    if (rst) begin
      m_pending = 0; m_target = '0; m_stall = 0; m_redir = 0;
      {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
      {e_ifid_fl, e_idex_fl, e_bub} = 3'b111;
    end else if (m_pending) begin
      e_pc = 0; e_ifid_fl = 1; care_ifid = 0; e_disc = if_busy;
      if (mem_busy) begin e_idex = 0; e_exmem = 0; e_bub = 1; end
      if (!if_busy) begin e_redir = 1; e_rpc = m_target; end
    end else if (mem_busy) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000; e_bub = 1;
    end else if (ex_valid && ex_redirect) begin
      e_ifid_fl = 1; e_idex_fl = 1; e_take = 1;
      if (if_busy) e_enter = 1;
      else begin e_redir = 1; e_rpc = ex_redirect_pc; end
    end else if (hz) begin
      e_pc = 0; e_ifid = 0; e_idex_fl = 1; care_idex = 0;
    end else if (if_busy) begin
      e_pc = 0; e_ifid_fl = 1; care_ifid = 0;
    end
  endtask

  // Inputs are already applied just after a negedge; check, then clock the model.
  task automatic step(input string tag);
    #2;
    predict();
    chk({tag, ":pc_en"}, pc_en, e_pc);
    if (care_ifid) chk({tag, ":if_id_en"}, if_id_en, e_ifid);
    if (care_idex) chk({tag, ":id_ex_en"}, id_ex_en, e_idex);
    chk({tag, ":ex_mem_en"}, ex_mem_en, e_exmem);
    chk({tag, ":mem_wb_en"}, mem_wb_en, e_memwb);
    chk({tag, ":if_id_flush"}, if_id_flush, e_ifid_fl);
    chk({tag, ":id_ex_flush"}, id_ex_flush, e_idex_fl);
    chk({tag, ":mem_wb_bubble"}, mem_wb_bubble, e_bub);
    chk({tag, ":fetch_redirect"}, fetch_redirect, e_redir);
    if (e_redir) chk({tag, ":fetch_redirect_pc"}, fetch_redirect_pc, e_rpc);
    chk({tag, ":fetch_discard"}, fetch_discard, e_disc);
    chk({tag, ":stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ":redirect_cnt"}, redirect_cnt, m_redir);
    chk({tag, ":no_double_redirect"}, prev_redirect & fetch_redirect, 0);
    prev_redirect = fetch_redirect;
    @(posedge clk);
    if (!rst) begin
      if (!e_pc && !e_redir) m_stall = m_stall + 1;
      if (e_take) m_redir = m_redir + 1;
      if (e_enter) begin m_pending = 1; m_target = ex_redirect_pc; end
      else if (m_pending && e_redir) m_pending = 0;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 0; if_busy = 0; mem_busy = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_valid = 0; ex_is_load = 0;
    ex_rd = 0; ex_redirect = 0; ex_redirect_pc = '0;
  endtask

  initial begin
    quiet();
    rst = 1; prev_redirect = 0;
    m_pending = 0; m_target = '0; m_stall = 0; m_redir = 0;
    @(negedge clk);
    step("reset");
    step("reset2");
    rst = 0;
    step("idle");

    // Redirect with fetch idle
    ex_valid = 1; ex_redirect = 1; ex_redirect_pc = 64'h8000_0100;
    step("redir_idle");
    quiet();
    step("after_redir_idle");

    // Redirect while fetch busy
    ex_valid = 1; ex_redirect = 1; ex_redirect_pc = 64'h8000_0100; if_busy = 1;
    step("redir_busy1");
    ex_valid = 0; ex_redirect = 0;
    step("redir_busy2");
    step("redir_busy3");
    if_busy = 0;
    step("redir_busy_release");
    step("redir_busy_after");

    // Load-use hazard, then the same with x0
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    step("load_use");
    ex_is_load = 0;
    step("load_use_done");
    ex_is_load = 1; ex_rd = 0; id_rs2 = 0;
    step("load_use_x0");
    quiet();

    // MEM busy holds back a redirect
    ex_valid = 1; ex_redirect = 1; ex_redirect_pc = 64'h0000_0000_1234_5678; mem_busy = 1;
    step("mem_busy1");
    step("mem_busy2");
    mem_busy = 0;
    step("mem_busy_release");
    quiet();

    // Reset while discarding
    ex_valid = 1; ex_redirect = 1; ex_redirect_pc = 64'hdead_beef_0000_0040; if_busy = 1;
    step("pre_discard");
    ex_valid = 0; ex_redirect = 0;
    step("in_discard");
    rst = 1;
    step("reset_in_discard");
    rst = 0;
    step("after_reset_busy");
    if_busy = 0;
    step("after_reset_idle");

    // Stall counter wrap
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFF;
    if_busy = 1;
    step("wrap");
    if_busy = 0;
    step("wrap_after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      if_busy        = ($urandom_range(0, 2) == 0);
      mem_busy       = ($urandom_range(0, 4) == 0);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom);
      id_use_rs2     = 1'($urandom);
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_is_load     = 1'($urandom);
      ex_rd          = 5'($urandom_range(0, 3));
      ex_redirect    = ($urandom_range(0, 5) == 0);
      ex_redirect_pc = {$urandom, $urandom};
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
